// File: rtl/maxpool_stream.sv
`default_nettype none
// ============================================================================
//  Module      : maxpool_stream
//  Description : Streaming 1-D max-pooling stage. Reduces each non-overlapping
//                window of POOL signed samples to its maximum and re-sends it
//                on a valid/ready interface. Frames are LEN samples long; the
//                LEN mod POOL trailing samples of a frame are accepted and
//                dropped. Optional macro MAXPOOL_RELU_EN clamps negative
//                results to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module maxpool_stream #(
    parameter int T    = 16,
    parameter int POOL = 2,
    parameter int LEN  = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [T-1:0] x_data,
    input  logic         x_valid,
    output logic         x_ready,
    output logic [T-1:0] y_data,
    output logic         y_valid,
    input  logic         y_ready,
    output logic         done
);

    localparam int c_NOUT = LEN / POOL;
    localparam int c_IW   = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int c_WW   = (POOL > 1) ? $clog2(POOL) : 1;
    localparam int c_OW   = (c_NOUT > 1) ? $clog2(c_NOUT) : 1;

    localparam logic [c_IW:0]   c_POOLED   = (c_IW + 1)'(c_NOUT * POOL);
    localparam logic [c_IW-1:0] c_IN_LAST  = c_IW'(LEN - 1);
    localparam logic [c_WW-1:0] c_WIN_LAST = c_WW'(POOL - 1);
    localparam logic [c_OW-1:0] c_OUT_LAST = c_OW'(c_NOUT - 1);

    logic [c_IW-1:0]       r_in_cnt;
    logic [c_WW-1:0]       r_win_cnt;
    logic [c_OW-1:0]       r_out_cnt;
    logic signed [T-1:0]   r_run_max;
    logic                  r_in_done;
    logic                  r_out_done;
    logic [T-1:0]          r_y_data;
    logic                  r_y_valid;
    logic                  r_done;

    logic signed [T-1:0]   w_x;
    logic signed [T-1:0]   w_max;
    logic [T-1:0]          w_result;
    logic                  w_in_pooled;
    logic                  w_completes;
    logic                  w_in_beat;
    logic                  w_out_beat;

    assign w_x         = $signed(x_data);
    assign w_max       = (w_x > r_run_max) ? w_x : r_run_max;
    assign w_in_pooled = ({1'b0, r_in_cnt} < c_POOLED);
    // Only the sample that closes a window inside the pooled region can stall.
    assign w_completes = (r_win_cnt == c_WIN_LAST) && w_in_pooled;
    assign x_ready     = !(r_y_valid && !y_ready && w_completes);
    assign w_in_beat   = x_valid && x_ready;
    assign w_out_beat  = r_y_valid && y_ready;

`ifdef MAXPOOL_RELU_EN
    // Clamp only the emitted value; the running maximum stays unclamped.
    assign w_result = w_max[T-1] ? '0 : w_max;
`else
    assign w_result = w_max;
`endif

    assign y_data  = r_y_data;
    assign y_valid = r_y_valid;
    assign done    = r_done;

    // Frame/window position and running maximum, advanced on each input beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_cnt  <= '0;
            r_win_cnt <= '0;
            r_run_max <= '0;
        end else if (w_in_beat) begin
            // The first sample of a window seeds the maximum.
            r_run_max <= (r_win_cnt == '0) ? w_x : w_max;
            if (r_in_cnt == c_IN_LAST) begin
                r_in_cnt  <= '0;
                r_win_cnt <= '0;
            end else begin
                r_in_cnt  <= r_in_cnt + 1'b1;
                r_win_cnt <= (r_win_cnt == c_WIN_LAST) ? '0 : r_win_cnt + 1'b1;
            end
        end
    end

    // Output register: a completing window overrides the consuming beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_y_data  <= '0;
            r_y_valid <= 1'b0;
        end else if (w_in_beat && w_completes) begin
            r_y_data  <= w_result;
            r_y_valid <= 1'b1;
        end else if (w_out_beat) begin
            r_y_valid <= 1'b0;
        end
    end

    // Accepted-output counter per frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_cnt <= '0;
        end else if (w_out_beat) begin
            r_out_cnt <= (r_out_cnt == c_OUT_LAST) ? '0 : r_out_cnt + 1'b1;
        end
    end

    // End-of-frame flags and the done pulse once both sides have finished.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_done  <= 1'b0;
            r_out_done <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= r_in_done && r_out_done;
            if (r_in_done && r_out_done) begin
                r_in_done  <= 1'b0;
                r_out_done <= 1'b0;
            end
            if (w_in_beat && (r_in_cnt == c_IN_LAST)) begin
                r_in_done <= 1'b1;
            end
            if (w_out_beat && (r_out_cnt == c_OUT_LAST)) begin
                r_out_done <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_maxpool_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_maxpool_stream
//  Description : Scoreboard bench for maxpool_stream over three configurations
//                (POOL/LEN = 2/8, 2/7, 4/8). A window-level reference model
//                queues expected results; a monitor pops them on output beats.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_maxpool_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int fin    = 0;
    int cycle  = 0;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic void chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic signed [15:0] rnd16();
        case ($urandom % 8)
            0:       return 16'sh8000;
            1:       return 16'sh7fff;
            2:       return 16'sh0000;
            default: return 16'($urandom);
        endcase
    endfunction

    // Directed sample tables; index >= LEN is the second directed frame.
    function automatic logic signed [15:0] dir_val(input int kk, input int i);
        if (kk == 0) begin
            case (i % 8)
                0: return 16'sd3;
                1: return -16'sd1;
                2: return 16'sd5;
                3: return 16'sd7;
                4: return -16'sd4;
                5: return -16'sd2;
                default: return 16'sd0;
            endcase
        end else if (kk == 1) begin
            return 16'((i % 7) + 1);
        end else begin
            if (i < 8)       return 16'sh8000;
            else if (i == 8) return 16'sh7fff;
            else if (i < 12) return 16'sh8000;
            else             return 16'(i * 100);
        end
    endfunction

    for (genvar k = 0; k < 3; k++) begin : g_cfg
        localparam int P  = (k == 2) ? 4 : 2;
        localparam int L  = (k == 1) ? 7 : 8;
        localparam int NO = L / P;

        logic               rst = 1'b1;
        logic signed [15:0] xd  = '0;
        logic               xv  = 1'b0;
        logic               yr  = 1'b0;
        logic               xr;
        logic [15:0]        yd;
        logic               yv;
        logic               dn;

        maxpool_stream #(.T(16), .POOL(P), .LEN(L)) dut (
            .clk    (clk),
            .reset  (rst),
            .x_data (xd),
            .x_valid(xv),
            .x_ready(xr),
            .y_data (yd),
            .y_valid(yv),
            .y_ready(yr),
            .done   (dn)
        );

        // Reference model: frame position, open window, pending results.
        int                 pos = 0;
        logic signed [15:0] win[$];
        logic signed [15:0] expq[$];
        int                 in_frames = 0;
        int                 out_frames = 0;
        int                 outs = 0;
        int                 dones = 0;
        bit                 b2b = 0;
        bit                 last_b2b = 0;
        int                 last_done = 0;
        bit                 hold = 0;
        logic [15:0]        hd = '0;

        task automatic model_in(input logic signed [15:0] d);
            logic signed [15:0] m;
            if (pos < NO * P) begin
                win.push_back(d);
                if (win.size() == P) begin
                    m = win[0];
                    foreach (win[j]) if (win[j] > m) m = win[j];
`ifdef MAXPOOL_RELU_EN
                    if (m < 0) m = 0;
`endif
                    expq.push_back(m);
                    win.delete();
                end
            end
            pos++;
            if (pos == L) begin
                pos = 0;
                in_frames++;
            end
        endtask

        // One clock of stimulus; checks handshake predictions before the edge.
        task automatic step(input logic v, input logic signed [15:0] d, input logic r, output logic acc);
            bit exp_xr;
            @(negedge clk);
            xv = v; xd = d; yr = r;
            #1;
            exp_xr = !((expq.size() != 0) && !r && (win.size() == P - 1) && (pos < NO * P));
            chk($sformatf("cfg%0d x_ready", k), xr, exp_xr);
            chk($sformatf("cfg%0d y_valid", k), yv, expq.size() != 0);
            acc = v && xr;
            if (acc) model_in(d);
        endtask

        task automatic drain();
            logic acc;
            for (int t = 0; t < 40 && expq.size() != 0; t++) step(1'b0, '0, 1'b1, acc);
            chk($sformatf("cfg%0d drain empty", k), expq.size(), 0);
            repeat (4) step(1'b0, '0, 1'b1, acc);
        endtask

        task automatic do_reset();
            @(negedge clk);
            rst = 1'b1; xv = 1'b0; yr = 1'b0;
            repeat (2) @(negedge clk);
            rst = 1'b0;
            pos = 0; outs = 0;
            win.delete(); expq.delete();
            in_frames = dones; out_frames = dones;
            #1;
            chk($sformatf("cfg%0d reset y_valid", k), yv, 0);
            chk($sformatf("cfg%0d reset y_data", k), yd, 0);
            chk($sformatf("cfg%0d reset done", k), dn, 0);
            chk($sformatf("cfg%0d reset x_ready", k), xr, 1);
        endtask

        // Monitor: pops expected results on output beats, checks hold and done.
        always @(negedge clk) begin
            logic signed [15:0] e;
            int owed;
            #2;
            if (rst) begin
                hold = 0;
            end else begin
                if (hold) begin
                    chk($sformatf("cfg%0d hold valid", k), yv, 1);
                    chk($sformatf("cfg%0d hold data", k), yd, hd);
                end
                hold = yv && !yr;
                hd = yd;
                if (yv && yr) begin
                    if (expq.size() == 0) begin
                        chk($sformatf("cfg%0d unexpected output", k), 1, 0);
                    end else begin
                        e = expq.pop_front();
                        chk($sformatf("cfg%0d y_data", k), $signed(yd), e);
                        outs++;
                        if (outs == NO) begin
                            outs = 0;
                            out_frames++;
                        end
                    end
                end
                if (dn) begin
                    owed = ((in_frames < out_frames) ? in_frames : out_frames) - dones;
                    chk($sformatf("cfg%0d done owed", k), owed > 0, 1);
                    dones++;
                    if (b2b && last_b2b) chk($sformatf("cfg%0d done spacing", k), cycle - last_done, L);
                    last_done = cycle;
                    last_b2b  = b2b;
                end
            end
        end

        initial begin
            logic acc;
            int s;
            do_reset();
            // Directed frame, no backpressure.
            for (int i = 0; i < L; i++) begin
                step(1'b1, dir_val(k, i), 1'b1, acc);
                chk($sformatf("cfg%0d accept free", k), acc, 1);
            end
            drain();
            // Directed frame with y_ready low for 6 cycles after first result.
            s = 0;
            for (int i = 0; i < L; i++) begin
                acc = 1'b0;
                for (int t = 0; t < 20 && !acc; t++) begin
                    step(1'b1, dir_val(k, L + i), !(s >= 2 && s < 8), acc);
                    s++;
                end
                chk($sformatf("cfg%0d accept stalled", k), acc, 1);
            end
            drain();
            // Two frames back to back at full rate.
            b2b = 1;
            for (int i = 0; i < 2 * L; i++) begin
                step(1'b1, rnd16(), 1'b1, acc);
                chk($sformatf("cfg%0d accept b2b", k), acc, 1);
            end
            drain();
            b2b = 0;
            // Reset in the middle of a frame with a result pending.
            for (int i = 0; i < 3; i++) step(1'b1, rnd16(), 1'b0, acc);
            do_reset();
            for (int i = 0; i < L; i++) step(1'b1, rnd16(), 1'b1, acc);
            drain();
            // Random traffic on both sides.
            for (int i = 0; i < 400; i++) begin
                step(($urandom % 4) != 0, rnd16(), ($urandom % 3) != 0, acc);
            end
            drain();
            chk($sformatf("cfg%0d done total", k), dones,
                (in_frames < out_frames) ? in_frames : out_frames);
            fin++;
        end
    end

    initial begin
        fork
            wait (fin == 3);
            begin
                #500000;
                errors++;
                $display("FAIL timeout: finished %0d of 3 configurations", fin);
            end
        join_any
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
